// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT constants and index helpers
package fft_pkg;
  localparam int DATA_W = 16;
  localparam int N_PTS  = 16;
  localparam int LOG2N  = 4;
  function automatic logic [LOG2N-1:0] bitrev4(input logic [LOG2N-1:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction
endpackage

// File: rtl/fft_out_reorder_if.sv
// fft_out_reorder_if: sample stream in from the FFT core, natural-order stream out
interface fft_out_reorder_if #(parameter int DATA_W = fft_pkg::DATA_W);
  logic              in_push;
  logic [DATA_W-1:0] in_real;
  logic [DATA_W-1:0] in_imag;
  logic              in_stall;
  logic              out_push_F;
  logic [DATA_W-1:0] out_real_F;
  logic [DATA_W-1:0] out_imag_F;
  logic              out_last_F;
  logic              out_stall;
  logic              ovf_F;
  modport master (
    output in_push, in_real, in_imag, out_stall,
    input  in_stall, out_push_F, out_real_F, out_imag_F, out_last_F, ovf_F
  );
  modport slave (
    input  in_push, in_real, in_imag, out_stall,
    output in_stall, out_push_F, out_real_F, out_imag_F, out_last_F, ovf_F
  );
endinterface

// File: rtl/reorder_bank.sv
// reorder_bank: 16-entry buffer, one write port, combinational read port
module reorder_bank #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         we,
  input  logic [3:0]   waddr,
  input  logic [W-1:0] wdata,
  input  logic [3:0]   raddr,
  output logic [W-1:0] rdata
);
  logic [W-1:0] mem [16];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: ping-pong buffer turning bit-reversed FFT output into natural order
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int N_PTS  = fft_pkg::N_PTS
) (
  input  logic clk,
  input  logic reset,
  fft_out_reorder_if.slave bus
);
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N_PTS - 1);
  logic [1:0]          sync;
  logic                rst_n_s;
  logic [LOG2N-1:0]    wr_cnt, rd_cnt;
  logic                wr_bank, rd_bank;
  logic [1:0]          full, full_n;
  logic                accept, wr_last, rd_go, rd_last;
  logic [2*DATA_W-1:0] rdata0, rdata1, rdata;
  // reset asserts immediately but releases two clocks later
  always_ff @(posedge clk or negedge reset)
    if (!reset) sync <= 2'b00;
    else sync <= {sync[0], 1'b1};
  assign rst_n_s = sync[1];
  assign bus.in_stall = full[wr_bank];
  assign accept  = bus.in_push & ~full[wr_bank];
  assign wr_last = accept & (wr_cnt == LAST);
  assign rd_go   = full[rd_bank] & ~bus.out_stall;
  assign rd_last = rd_go & (rd_cnt == LAST);
  assign rdata   = rd_bank ? rdata1 : rdata0;
  always_comb begin
    full_n = full;
    if (rd_last) full_n[rd_bank] = 1'b0;
    if (wr_last) full_n[wr_bank] = 1'b1;
  end
  reorder_bank #(.W(2*DATA_W)) bank0 (
    .clk(clk), .we(accept & ~wr_bank), .waddr(bitrev4(wr_cnt)),
    .wdata({bus.in_real, bus.in_imag}), .raddr(rd_cnt), .rdata(rdata0)
  );
  reorder_bank #(.W(2*DATA_W)) bank1 (
    .clk(clk), .we(accept & wr_bank), .waddr(bitrev4(wr_cnt)),
    .wdata({bus.in_real, bus.in_imag}), .raddr(rd_cnt), .rdata(rdata1)
  );
  always_ff @(posedge clk or negedge rst_n_s)
    if (!rst_n_s) begin
      wr_cnt         <= '0;
      rd_cnt         <= '0;
      wr_bank        <= 1'b0;
      rd_bank        <= 1'b0;
      full           <= 2'b00;
      bus.out_push_F <= 1'b0;
      bus.out_last_F <= 1'b0;
      bus.out_real_F <= '0;
      bus.out_imag_F <= '0;
      bus.ovf_F      <= 1'b0;
    end else begin
      full           <= full_n;
      bus.out_push_F <= rd_go;
      bus.out_last_F <= rd_last;
      if (accept) wr_cnt <= wr_cnt + 1'b1;
      if (wr_last) wr_bank <= ~wr_bank;
      if (rd_go) rd_cnt <= rd_cnt + 1'b1;
      if (rd_last) rd_bank <= ~rd_bank;
      if (rd_go) {bus.out_real_F, bus.out_imag_F} <= rdata;
      if (bus.in_push & full[wr_bank]) bus.ovf_F <= 1'b1;
    end
endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: table vectors, corner sequences and random traffic vs a frame-queue model
module tb_fft_out_reorder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  fft_out_reorder_if bus();
  fft_out_reorder dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic push; logic [15:0] re; logic [15:0] im; logic os;
    logic e_push; logic [15:0] e_re; logic [15:0] e_im; logic e_last;
  } vec_t;
  vec_t tbl[34];
  int exp_seq[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  int vec_n = 0, miss_n = 0, npush = 0, stall_seen = 0;
  logic [31:0] outq[$];
  logic [31:0] part[16];
  int pcnt = 0;
  logic e_push = 1'b0, e_last = 1'b0, e_ovf = 1'b0;
  logic [31:0] e_data = '0;

  function automatic int rev4(input int x);
    int r = 0;
    for (int b = 0; b < 4; b++) if (x[b]) r = r | (1 << (3 - b));
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    outq.delete();
    pcnt = 0; e_push = 0; e_last = 0; e_ovf = 0; e_data = '0;
  endtask

  // outq holds complete frames already in natural order; a frame is buffered until fully drained
  task automatic step(input logic p, input logic [15:0] r, input logic [15:0] i, input logic os);
    int nfr;
    bus.in_push = p; bus.in_real = r; bus.in_imag = i; bus.out_stall = os;
    nfr = (outq.size() + 15) / 16;
    chk("in_stall", 32'(bus.in_stall), 32'(nfr == 2));
    stall_seen += int'(bus.in_stall);
    @(posedge clk); #1;
    e_push = 0; e_last = 0;
    if (outq.size() > 0 && !os) begin
      e_push = 1;
      e_data = outq.pop_front();
      e_last = (outq.size() % 16 == 0);
    end
    if (p) begin
      if (nfr == 2) e_ovf = 1;
      else begin
        part[pcnt] = {r, i};
        pcnt++;
        if (pcnt == 16) begin
          for (int j = 0; j < 16; j++) outq.push_back(part[rev4(j)]);
          pcnt = 0;
        end
      end
    end
    npush += int'(bus.out_push_F);
    chk("out_push_F", 32'(bus.out_push_F), 32'(e_push));
    chk("out_data", {bus.out_real_F, bus.out_imag_F}, e_data);
    chk("out_last_F", 32'(bus.out_last_F), 32'(e_last));
    chk("ovf_F", 32'(bus.ovf_F), 32'(e_ovf));
  endtask

  task automatic do_reset();
    bus.in_push = 0; bus.out_stall = 0; reset = 0; #1;
    chk("rst_push", 32'(bus.out_push_F), 0);
    chk("rst_data", {bus.out_real_F, bus.out_imag_F}, 0);
    chk("rst_last", 32'(bus.out_last_F), 0);
    chk("rst_ovf", 32'(bus.ovf_F), 0);
    chk("rst_in_stall", 32'(bus.in_stall), 0);
    repeat (2) @(posedge clk);
    #1; reset = 1;
    repeat (3) @(posedge clk);
    #1; model_clear();
  endtask

  task automatic ordered_frame(input string name, input int ostall_a, input int ostall_b);
    int idx = 0;
    int got[16];
    for (int k = 0; k < 16; k++) step(1, 16'(k), 16'(-k), 0);
    npush = 0;
    for (int n = 0; n < 18; n++) begin
      step(0, 16'h0, 16'h0, n == ostall_a || n == ostall_b);
      if (bus.out_push_F && idx < 16) begin got[idx] = int'(bus.out_real_F); idx++; end
    end
    chk({name, "_count"}, 32'(npush), 16);
    for (int j = 0; j < 16; j++) chk({name, "_bin"}, 32'(got[j]), 32'(exp_seq[j]));
  endtask

  initial begin
    int first;
    bus.in_push = 0; bus.in_real = '0; bus.in_imag = '0; bus.out_stall = 0;
    #3; do_reset();
    for (int k = 0; k < 16; k++)
      tbl[k] = '{push: 1'b1, re: 16'(k), im: 16'(-k), os: 1'b0,
                 e_push: 1'b0, e_re: 16'h0, e_im: 16'h0, e_last: 1'b0};
    for (int j = 0; j < 16; j++)
      tbl[16+j] = '{push: 1'b0, re: 16'h0, im: 16'h0, os: 1'b0, e_push: 1'b1,
                    e_re: 16'(exp_seq[j]), e_im: 16'(-exp_seq[j]), e_last: j == 15};
    for (int j = 32; j < 34; j++)
      tbl[j] = '{push: 1'b0, re: 16'h0, im: 16'h0, os: 1'b0,
                 e_push: 1'b0, e_re: 16'd15, e_im: 16'hFFF1, e_last: 1'b0};
    for (int n = 0; n < 34; n++) begin
      step(tbl[n].push, tbl[n].re, tbl[n].im, tbl[n].os);
      chk("tbl_push", 32'(bus.out_push_F), 32'(tbl[n].e_push));
      chk("tbl_real", 32'(bus.out_real_F), 32'(tbl[n].e_re));
      chk("tbl_imag", 32'(bus.out_imag_F), 32'(tbl[n].e_im));
      chk("tbl_last", 32'(bus.out_last_F), 32'(tbl[n].e_last));
    end
    // three back-to-back frames, never stalled
    do_reset();
    npush = 0; stall_seen = 0; first = -1;
    for (int n = 0; n < 64; n++) begin
      step(n < 48, 16'($urandom), 16'($urandom), 0);
      if (first < 0 && bus.out_push_F) first = n;
    end
    chk("b2b_in_stall", 32'(stall_seen), 0);
    chk("b2b_pushes", 32'(npush), 48);
    chk("b2b_first", 32'(first), 16);
    // both banks fill while downstream is stalled; 33rd push overflows
    do_reset();
    for (int n = 0; n < 32; n++) step(1, 16'($urandom), 16'($urandom), 1);
    chk("full_in_stall", 32'(bus.in_stall), 1);
    chk("full_ovf_clear", 32'(bus.ovf_F), 0);
    step(1, 16'hDEAD, 16'hBEEF, 1);
    chk("ovf_set", 32'(bus.ovf_F), 1);
    npush = 0;
    repeat (40) step(0, 16'h0, 16'h0, 0);
    chk("drain_pushes", 32'(npush), 32);
    // downstream stall pulse at bins 3 and 4
    do_reset();
    ordered_frame("pause", 3, 4);
    // reset in the middle of a frame
    for (int k = 0; k < 7; k++) step(1, 16'(k + 100), 16'(k + 200), 0);
    do_reset();
    ordered_frame("post_rst", -1, -1);
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), $urandom_range(0, 2) == 0);
    repeat (40) step(0, 16'h0, 16'h0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end
endmodule
